sobel_gradient_engine: RTL

Parametrised successor to the 3x3 gradient-magnitude block in the edge-detection pipeline. Accepts one packed 3x3 pixel window under the Enable/done handshake and computes Sobel Gx and Gy serially, one tap per cycle. It then forms a selectable magnitude, saturated to pixel width. Its output feeds the thresholding stage; an optional built-in double threshold is available.

---
 rtl/sobel_gradient_engine.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/sobel_gradient_engine.sv
// Serial 3x3 Sobel engine: Gx/Gy one tap per cycle, then a saturated magnitude by mode.
// Optional GRAD_THRESH_EN adds a registered double-threshold edge class.
module sobel_gradient_engine #(
  parameter int PIX_W  = 8,
  parameter int ELEM_W = 24,
  parameter int ACC_W  = PIX_W + 4
) (
  input  logic                    Clock,
  input  logic                    reset,
  input  logic                    Enable,
  input  logic [9*ELEM_W-1:0]     A,
  input  logic [1:0]              mode,
`ifdef GRAD_THRESH_EN
  input  logic [PIX_W-1:0]        thr_lo,
  input  logic [PIX_W-1:0]        thr_hi,
  output logic [1:0]              edge_class,
`endif
  output logic                    busy,
  output logic                    done,
  output logic [ELEM_W-1:0]       GM,
  output logic signed [ACC_W-1:0] GX,
  output logic signed [ACC_W-1:0] GY
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_MAG   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [ACC_W+1:0] PIX_MAX = (ACC_W+2)'((1 << PIX_W) - 1);

  logic [1:0]              r_state;
  logic [3:0]              r_tap;
  logic [PIX_W-1:0]        r_win [0:8];
  logic [1:0]              r_mode;
  logic signed [ACC_W-1:0] r_gx_acc, r_gy_acc;
  logic                    r_busy, r_done;
  logic [ELEM_W-1:0]       r_gm;
  logic signed [ACC_W-1:0] r_gx, r_gy;
`ifdef GRAD_THRESH_EN
  logic [1:0]              r_edge_class;
`endif

  logic signed [ACC_W-1:0] w_p, w_p2, w_dx, w_dy;
  logic signed [ACC_W:0]   w_gxe, w_gye;
  logic [ACC_W:0]          w_ax, w_ay, w_max, w_min;
  logic [ACC_W+1:0]        w_mag;
  logic [PIX_W-1:0]        w_gm;
  logic                    w_unused;

  // Only the low PIX_W bits of each packed element carry pixel data.
  assign w_unused = ^A;

  assign w_p  = $signed(ACC_W'(r_win[r_tap]));
  assign w_p2 = w_p <<< 1;

  // Kernel weights per row-major tap, realised as shift/negate of the pixel.
  always_comb begin
    w_dx = '0;
    w_dy = '0;
    case (r_tap)
      4'd0: begin w_dx = -w_p;  w_dy = -w_p;  end
      4'd1: begin               w_dy = -w_p2; end
      4'd2: begin w_dx = w_p;   w_dy = -w_p;  end
      4'd3: begin w_dx = -w_p2;               end
      4'd5: begin w_dx = w_p2;                end
      4'd6: begin w_dx = -w_p;  w_dy = w_p;   end
      4'd7: begin               w_dy = w_p2;  end
      4'd8: begin w_dx = w_p;   w_dy = w_p;   end
      default: ;
    endcase
  end

  // One extra bit so |most negative| cannot wrap.
  assign w_gxe = {r_gx_acc[ACC_W-1], r_gx_acc};
  assign w_gye = {r_gy_acc[ACC_W-1], r_gy_acc};
  assign w_ax  = w_gxe[ACC_W] ? $unsigned(-w_gxe) : $unsigned(w_gxe);
  assign w_ay  = w_gye[ACC_W] ? $unsigned(-w_gye) : $unsigned(w_gye);
  assign w_max = (w_ax >= w_ay) ? w_ax : w_ay;
  assign w_min = (w_ax >= w_ay) ? w_ay : w_ax;

  always_comb begin
    w_mag = '0;
    case (r_mode)
      2'd1:    w_mag = {1'b0, w_max};
      2'd2:    w_mag = {1'b0, w_max} + {2'b00, w_min[ACC_W:1]};
      default: w_mag = {1'b0, w_ax} + {1'b0, w_ay};
    endcase
  end

  assign w_gm = (w_mag > PIX_MAX) ? {PIX_W{1'b1}} : w_mag[PIX_W-1:0];

  always_ff @(posedge Clock or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_tap    <= '0;
      r_mode   <= '0;
      r_gx_acc <= '0;
      r_gy_acc <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_gm     <= '0;
      r_gx     <= '0;
      r_gy     <= '0;
      for (int k = 0; k < 9; k++) r_win[k] <= '0;
`ifdef GRAD_THRESH_EN
      r_edge_class <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (Enable) begin
            for (int k = 0; k < 9; k++) r_win[k] <= A[k*ELEM_W +: PIX_W];
            r_mode   <= mode;
            r_gx_acc <= '0;
            r_gy_acc <= '0;
            r_tap    <= '0;
            r_busy   <= 1'b1;
            r_state  <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          r_gx_acc <= r_gx_acc + w_dx;
          r_gy_acc <= r_gy_acc + w_dy;
          if (r_tap == 4'd8) begin
            r_tap   <= '0;
            r_state <= S_MAG;
          end else begin
            r_tap <= r_tap + 4'd1;
          end
        end
        S_MAG: begin
          r_gx    <= r_gx_acc;
          r_gy    <= r_gy_acc;
          r_gm    <= ELEM_W'(w_gm);
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_DONE;
`ifdef GRAD_THRESH_EN
          if (w_gm >= thr_hi)      r_edge_class <= 2'd2;
          else if (w_gm >= thr_lo) r_edge_class <= 2'd1;
          else                     r_edge_class <= 2'd0;
`endif
        end
        default: begin
          // Leaving requires Enable low, so a held request cannot restart.
          if (!Enable) begin
            r_done  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign GM   = r_gm;
  assign GX   = r_gx;
  assign GY   = r_gy;
`ifdef GRAD_THRESH_EN
  assign edge_class = r_edge_class;
`endif

endmodule
